// File: rtl/channel_error_injector.sv
// Noisy-channel stage: registers 2-bit encoded symbols and XORs in LFSR-driven error masks.
// Latency: 1 cycle from valid_i/d_in to valid_o/d_out.
// Backpressure: none; accepts a symbol on every valid_i cycle, gaps freeze all channel state.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   enable_i           1 = inject errors, 0 = clean pass-through (also aborts a burst)
//   burst_i            0 = isolated random errors, 1 = bursts of burst_len_i symbols
//   burst_len_i        burst length in symbols, 0 behaves as 1
//   clr_i              synchronous clear of both counters (wins over a same-cycle symbol)
//   valid_i, d_in      incoming encoded symbol
//   valid_o, d_out     registered, possibly corrupted symbol
//   err_mask_o         mask that was applied to the current d_out
//   err_ct_o, sym_ct_o saturating bit-error and symbol counts
module channel_error_injector #(
   parameter int          N    = 5,
   parameter logic [31:0] SEED = 32'hACE1_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic        burst_i,
   input  logic [3:0]  burst_len_i,
   input  logic        clr_i,
   input  logic        valid_i,
   input  logic [1:0]  d_in,
   output logic        valid_o,
   output logic [1:0]  d_out,
   output logic [1:0]  err_mask_o,
   output logic [15:0] err_ct_o,
   output logic [15:0] sym_ct_o
);

   // x^32 + x^22 + x^2 + x + 1, Galois right-shift form
   localparam logic [31:0] TAPS     = 32'h8020_0003;
   // An all-zero LFSR would lock up, so a zero seed is replaced
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   // Low N bits compared against zero; N=0 gives an empty mask so every symbol is an event
   localparam logic [31:0] EV_MASK  = (N == 0) ? 32'h0 : ((32'h1 << N) - 32'h1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t      state, state_nxt;
   logic [3:0]  rem, rem_nxt;
   logic [31:0] lfsr, lfsr_nxt;
   logic        ev;
   logic [1:0]  cand;
   logic [1:0]  mask;
   logic [3:0]  len_m1;
   logic [16:0] err_sum;

   always_comb begin
      lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
      ev       = enable_i & ((lfsr & EV_MASK) == 32'h0);
      // A mask of 00 would be a silent event; force a single-bit error instead
      cand     = (lfsr[31:30] == 2'b00) ? 2'b01 : lfsr[31:30];
      len_m1   = (burst_len_i == 4'd0) ? 4'd0 : burst_len_i - 4'd1;
   end

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      mask      = 2'b00;
      if (valid_i) begin
         case (state)
            IDLE: begin
               if (ev) begin
                  mask = cand;
                  if (burst_i) begin
                     // First symbol of the burst is this one; rem counts the rest
                     rem_nxt = len_m1;
                     if (len_m1 != 4'd0) state_nxt = BURST;
                  end
               end
            end
            BURST: begin
               if (!enable_i) begin
                  state_nxt = IDLE;
                  rem_nxt   = 4'd0;
               end else begin
                  // Events during a burst are absorbed: mask applies regardless of ev
                  mask    = cand;
                  rem_nxt = rem - 4'd1;
                  if (rem == 4'd1) state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               rem_nxt   = 4'd0;
            end
         endcase
      end
   end

   assign err_sum = {1'b0, err_ct_o} + {16'b0, mask[0]} + {16'b0, mask[1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rem        <= 4'd0;
         lfsr       <= SEED_EFF;
         valid_o    <= 1'b0;
         d_out      <= 2'b00;
         err_mask_o <= 2'b00;
      end else begin
         state      <= state_nxt;
         rem        <= rem_nxt;
         valid_o    <= valid_i;
         err_mask_o <= mask;
         if (valid_i) begin
            lfsr  <= lfsr_nxt;
            d_out <= d_in ^ mask;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_ct_o <= 16'h0;
         sym_ct_o <= 16'h0;
      end else if (clr_i) begin
         err_ct_o <= 16'h0;
         sym_ct_o <= 16'h0;
      end else if (valid_i) begin
         err_ct_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         if (sym_ct_o != 16'hFFFF) sym_ct_o <= sym_ct_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_channel_error_injector.sv
// Bench for channel_error_injector: two instances (N=0, N=5) driven by shared stimulus.
// Each is checked every cycle against a symbol-level reference model.
// Directed phases cover pass-through, clear, bursts, mid-burst reset and saturation.
module tb_channel_error_injector;

   localparam logic [31:0] SEED = 32'hACE1_0001;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk;
   logic        rst;
   logic        enable_i;
   logic        burst_i;
   logic [3:0]  burst_len_i;
   logic        clr_i;
   logic        valid_i;
   logic [1:0]  d_in;

   logic        valid_o    [2];
   logic [1:0]  d_out      [2];
   logic [1:0]  err_mask_o [2];
   logic [15:0] err_ct_o   [2];
   logic [15:0] sym_ct_o   [2];

   channel_error_injector #(.N(0), .SEED(SEED)) u_dut0 (
      .clk(clk), .rst(rst), .enable_i(enable_i), .burst_i(burst_i),
      .burst_len_i(burst_len_i), .clr_i(clr_i), .valid_i(valid_i), .d_in(d_in),
      .valid_o(valid_o[0]), .d_out(d_out[0]), .err_mask_o(err_mask_o[0]),
      .err_ct_o(err_ct_o[0]), .sym_ct_o(sym_ct_o[0]));

   channel_error_injector #(.N(5), .SEED(SEED)) u_dut5 (
      .clk(clk), .rst(rst), .enable_i(enable_i), .burst_i(burst_i),
      .burst_len_i(burst_len_i), .clr_i(clr_i), .valid_i(valid_i), .d_in(d_in),
      .valid_o(valid_o[1]), .d_out(d_out[1]), .err_mask_o(err_mask_o[1]),
      .err_ct_o(err_ct_o[1]), .sym_ct_o(sym_ct_o[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: channel as a stream of symbols with a "symbols left in burst" count
   logic [31:0] m_lfsr [2];
   int          m_left [2];
   logic        m_vld  [2];
   logic [1:0]  m_dout [2];
   logic [1:0]  m_mask [2];
   int          m_err  [2];
   int          m_sym  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lfsr[i] = SEED;
         m_left[i] = 0;
         m_vld[i]  = 1'b0;
         m_dout[i] = 2'b00;
         m_mask[i] = 2'b00;
         m_err[i]  = 0;
         m_sym[i]  = 0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         int          nv;
         int          len;
         logic [31:0] L;
         logic [1:0]  m;
         logic [1:0]  mk;
         logic        ev;
         nv = (i == 0) ? 0 : 5;
         L  = m_lfsr[i];
         mk = 2'b00;
         if (valid_i) begin
            ev = enable_i && ((L % (32'd1 << nv)) == 32'd0);
            m  = (L[31:30] == 2'b00) ? 2'b01 : L[31:30];
            if (m_left[i] > 0) begin
               if (enable_i) begin
                  mk = m;
                  m_left[i] = m_left[i] - 1;
               end else begin
                  m_left[i] = 0;
               end
            end else if (ev) begin
               mk = m;
               if (burst_i) begin
                  len = (burst_len_i == 4'd0) ? 1 : int'(burst_len_i);
                  m_left[i] = len - 1;
               end
            end
            m_dout[i] = d_in ^ mk;
            m_lfsr[i] = L[0] ? ((L >> 1) ^ TAPS) : (L >> 1);
         end
         m_vld[i]  = valid_i;
         m_mask[i] = mk;
         if (clr_i) begin
            m_err[i] = 0;
            m_sym[i] = 0;
         end else if (valid_i) begin
            m_err[i] = (m_err[i] + int'(mk[0]) + int'(mk[1]) > 65535) ? 65535
                       : m_err[i] + int'(mk[0]) + int'(mk[1]);
            m_sym[i] = (m_sym[i] + 1 > 65535) ? 65535 : m_sym[i] + 1;
         end
      end
   endtask

   task automatic check_model();
      chk("n0_valid", 32'(valid_o[0]),    32'(m_vld[0]));
      chk("n0_dout",  32'(d_out[0]),      32'(m_dout[0]));
      chk("n0_mask",  32'(err_mask_o[0]), 32'(m_mask[0]));
      chk("n0_errct", 32'(err_ct_o[0]),   32'(m_err[0]));
      chk("n0_symct", 32'(sym_ct_o[0]),   32'(m_sym[0]));
      chk("n5_valid", 32'(valid_o[1]),    32'(m_vld[1]));
      chk("n5_dout",  32'(d_out[1]),      32'(m_dout[1]));
      chk("n5_mask",  32'(err_mask_o[1]), 32'(m_mask[1]));
      chk("n5_errct", 32'(err_ct_o[1]),   32'(m_err[1]));
      chk("n5_symct", 32'(sym_ct_o[1]),   32'(m_sym[1]));
   endtask

   // Inputs are changed at the negedge; the model follows the posedge; outputs are read at the negedge
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic set_in(input logic en, input logic bu, input logic [3:0] len,
                         input logic cl, input logic v, input logic [1:0] d);
      enable_i    = en;
      burst_i     = bu;
      burst_len_i = len;
      clr_i       = cl;
      valid_i     = v;
      d_in        = d;
   endtask

   logic [1:0] rec [2][40];

   initial begin
      int waited;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      model_reset();
      step();
      step();
      for (int i = 0; i < 2; i++) begin
         chk("rst_valid", 32'(valid_o[i]),    32'd0);
         chk("rst_dout",  32'(d_out[i]),      32'd0);
         chk("rst_mask",  32'(err_mask_o[i]), 32'd0);
         chk("rst_errct", 32'(err_ct_o[i]),   32'd0);
         chk("rst_symct", 32'(sym_ct_o[i]),   32'd0);
      end

      // Power-up reference run: bursts of 15 from SEED, recorded from the model
      rst = 1'b0;
      set_in(1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 2'b00);
      for (int k = 0; k < 40; k++) begin
         step();
         rec[0][k] = m_dout[0];
         rec[1][k] = m_dout[1];
      end

      // Pass-through of 100 symbols (first clear the counters)
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00);
      step();
      set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b10);
      for (int k = 0; k < 100; k++) begin
         step();
         chk("pass_dout", 32'(d_out[1]), 32'd2);
         chk("pass_mask", 32'(err_mask_o[0]), 32'd0);
      end
      for (int i = 0; i < 2; i++) begin
         chk("pass_symct", 32'(sym_ct_o[i]), 32'd100);
         chk("pass_errct", 32'(err_ct_o[i]), 32'd0);
      end

      // Random mode, every symbol an event for N=0
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00);
      for (int k = 0; k < 64; k++) begin
         step();
         chk("n0_nonzero", 32'(d_out[0] != 2'b00), 32'd1);
      end

      // Burst mode, length 8, valid toggling
      for (int k = 0; k < 600; k++) begin
         set_in(1'b1, 1'b1, 4'd8, 1'b0, 1'(k % 2), 2'($urandom));
         step();
      end

      // Fully random mix, including len 0, enable drops, mode changes and clears
      for (int k = 0; k < 3000; k++) begin
         set_in(1'($urandom_range(0, 7) != 0), 1'($urandom), 4'($urandom),
                1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), 2'($urandom));
         step();
      end

      // Clear coincident with an erred symbol
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00);
      step();
      set_in(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 2'b00);
      step();
      chk("clr_symct", 32'(sym_ct_o[0]), 32'd0);
      chk("clr_errct", 32'(err_ct_o[0]), 32'd0);
      chk("clr_dout_erred", 32'(d_out[0] != 2'b00), 32'd1);

      // Mid-burst reset, then replay the power-up stimulus
      set_in(1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 2'b00);
      waited = 0;
      step();
      while (m_left[1] == 0 && waited < 3000) begin
         step();
         waited++;
      end
      chk("burst_reached", 32'(m_left[1] > 0), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid_o[1]), 32'd0);
      chk("arst_dout",  32'(d_out[1]),   32'd0);
      chk("arst_mask",  32'(err_mask_o[1]), 32'd0);
      chk("arst_symct", 32'(sym_ct_o[1]), 32'd0);
      @(negedge clk);
      step();
      rst = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         chk("replay_n0", 32'(d_out[0]), 32'(rec[0][k]));
         chk("replay_n5", 32'(d_out[1]), 32'(rec[1][k]));
      end

      // Saturation: 70000 back-to-back symbols, N=0 errs every one
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00);
      for (int k = 0; k < 70000; k++) begin
         d_in = 2'($urandom);
         step();
      end
      chk("sat_n0_symct", 32'(sym_ct_o[0]), 32'hFFFF);
      chk("sat_n0_errct", 32'(err_ct_o[0]), 32'hFFFF);
      chk("sat_n5_symct", 32'(sym_ct_o[1]), 32'hFFFF);
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 2'b11);
      step();
      chk("sat_hold_symct", 32'(sym_ct_o[0]), 32'hFFFF);
      chk("sat_hold_errct", 32'(err_ct_o[0]), 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
